// File: rtl/move_scheduler_if.sv
// ---------------------------------------------------------------------------
// move_scheduler_if
//
// Bundles the player-side inputs and the game-side command outputs of
// move_scheduler. The clock and reset remain plain ports on the module.
//
//   btn_right_raw / btn_left_raw / btn_drop_raw : raw asynchronous buttons, active high
//   frame_start : one-cycle pulse at the start of vertical blanking
//   game_over   : level from the game core
//   move_right / move_left / drop_piece : registered one-cycle command pulses
//   cmd_pending : high while a command is held but not yet issued
//
// Modports:
//   master : the environment side (drives buttons/timing, receives commands)
//   slave  : the scheduler itself
// ---------------------------------------------------------------------------
interface move_scheduler_if;
  logic btn_right_raw;
  logic btn_left_raw;
  logic btn_drop_raw;
  logic frame_start;
  logic game_over;
  logic move_right;
  logic move_left;
  logic drop_piece;
  logic cmd_pending;

  modport master (
    output btn_right_raw, btn_left_raw, btn_drop_raw, frame_start, game_over,
    input  move_right, move_left, drop_piece, cmd_pending
  );

  modport slave (
    input  btn_right_raw, btn_left_raw, btn_drop_raw, frame_start, game_over,
    output move_right, move_left, drop_piece, cmd_pending
  );
endinterface

// File: rtl/move_scheduler.sv
// ---------------------------------------------------------------------------
// move_scheduler
//
// Turns three raw player buttons into single-cycle move commands for the
// connect_four core. Each button is synchronised (two flops), debounced and
// edge-detected into a request. One request is held in a slot and issued only
// at frame_start, so the board never changes during active video. After each
// issue the scheduler waits one more frame before it accepts a new request.
//
// Ports:
//   clk_25MHz : pixel clock, the only clock
//   rst_n     : asynchronous active-low reset
//   bus       : move_scheduler_if.slave (buttons, frame_start, game_over in;
//               move_right, move_left, drop_piece, cmd_pending out)
//
// Parameters:
//   DEBOUNCE_CYCLES : consecutive stable cycles needed to accept a new level
//   CNT_W           : debounce counter width, 2**CNT_W > DEBOUNCE_CYCLES
//   REPEAT_FRAMES   : frames between auto-repeats (HOLD_REPEAT_EN only)
//
// Optional feature (macro HOLD_REPEAT_EN): while the debounced left or right
// level stays high, every REPEAT_FRAMES frame_start pulses raise a synthetic
// request for that direction. Drop never repeats. Without the macro there is
// exactly one request per press.
// ---------------------------------------------------------------------------
module move_scheduler #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 18,
  parameter int REPEAT_FRAMES   = 15
) (
  input logic              clk_25MHz,
  input logic              rst_n,
  move_scheduler_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PENDING  = 2'd1,
    ISSUE    = 2'd2,
    COOLDOWN = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    SLOT_NONE  = 2'b00,
    SLOT_RIGHT = 2'b01,
    SLOT_LEFT  = 2'b10,
    SLOT_DROP  = 2'b11
  } slot_t;

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Button vectors: bit 0 = right, bit 1 = left, bit 2 = drop.
  logic [2:0]       sync1_q, sync2_q;
  logic [2:0]       stable_q, stable_d1_q;
  logic [CNT_W-1:0] db_cnt_q [3];
  logic [2:0]       rise;
  logic [2:0]       req;
  slot_t            req_slot;

  state_t state_q, state_d;
  slot_t  slot_q,  slot_d;
  logic   right_q, left_q, drop_q;
  logic   right_d, left_d, drop_d;

  // -------------------------------------------------------------------------
  // Synchronisers, debounce and edge detect
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others; blocking here would collapse the
  // two-flop synchroniser into one.
  // NOTE: the per-button counter array is small control state, not storage,
  // so every entry is reset explicitly.
  always_ff @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      stable_q    <= '0;
      stable_d1_q <= '0;
      for (int i = 0; i < 3; i++) db_cnt_q[i] <= '0;
    end else begin
      sync1_q     <= {bus.btn_drop_raw, bus.btn_left_raw, bus.btn_right_raw};
      sync2_q     <= sync1_q;
      stable_d1_q <= stable_q;
      for (int i = 0; i < 3; i++) begin
        if (sync2_q[i] == stable_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DB_LAST) begin
          stable_q[i] <= sync2_q[i];
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  assign rise = stable_q & ~stable_d1_q;

`ifdef HOLD_REPEAT_EN
  localparam int             RW      = $clog2(REPEAT_FRAMES + 1);
  localparam logic [RW-1:0]  REP_LAST = RW'(REPEAT_FRAMES - 1);

  logic [RW-1:0] rep_cnt_q [2];
  logic [1:0]    rep_req;

  // Synthetic request fires on the frame_start that completes a repeat period.
  always_comb begin
    for (int i = 0; i < 2; i++)
      rep_req[i] = stable_q[i] & bus.frame_start & (rep_cnt_q[i] == REP_LAST);
  end

  always_ff @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) rep_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (!stable_q[i])
          rep_cnt_q[i] <= '0;
        else if (bus.frame_start)
          rep_cnt_q[i] <= (rep_cnt_q[i] == REP_LAST) ? '0 : rep_cnt_q[i] + RW'(1);
      end
    end
  end

  assign req = rise | {1'b0, rep_req};
`else
  // REPEAT_FRAMES only matters with auto-repeat; keep it referenced.
  logic unused_cfg;
  assign unused_cfg = (REPEAT_FRAMES > 0);
  assign req        = rise;
`endif

  // Priority DROP > LEFT > RIGHT; losing requests are dropped.
  always_comb begin
    if      (req[2]) req_slot = SLOT_DROP;
    else if (req[1]) req_slot = SLOT_LEFT;
    else if (req[0]) req_slot = SLOT_RIGHT;
    else             req_slot = SLOT_NONE;
  end

  // -------------------------------------------------------------------------
  // Command FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      slot_q  <= SLOT_NONE;
      right_q <= 1'b0;
      left_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      right_q <= right_d;
      left_q  <= left_d;
      drop_q  <= drop_d;
    end
  end

  // NOTE: every output of this block is given a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    right_d = 1'b0;
    left_d  = 1'b0;
    drop_d  = 1'b0;
    case (state_q)
      IDLE: begin
        // A drop is meaningless once the game has ended.
        if (req_slot != SLOT_NONE && !(req_slot == SLOT_DROP && bus.game_over)) begin
          slot_d  = req_slot;
          state_d = PENDING;
        end
      end
      PENDING: begin
        if (bus.frame_start) state_d = ISSUE;
      end
      ISSUE: begin
        right_d = (slot_q == SLOT_RIGHT);
        left_d  = (slot_q == SLOT_LEFT);
        // game_over may have risen while the drop waited for blanking.
        drop_d  = (slot_q == SLOT_DROP) && !bus.game_over;
        slot_d  = SLOT_NONE;
        state_d = COOLDOWN;
      end
      COOLDOWN: begin
        if (bus.frame_start) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        slot_d  = SLOT_NONE;
      end
    endcase
  end

  assign bus.move_right  = right_q;
  assign bus.move_left   = left_q;
  assign bus.drop_piece  = drop_q;
  assign bus.cmd_pending = (state_q == PENDING);

endmodule
